// File: rtl/dma_fifo_mc_exmem.sv
// Multi-channel FIFO controller over an external single-port-per-direction RAM.
// Each channel owns a DEPTH-entry region addressed as {channel, pointer}.
module dma_fifo_mc_exmem #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 8,
  parameter int NCH    = 4,
  parameter int AF_LVL = 4,
  parameter int AE_LVL = 4,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [CW-1:0]             push_ch,
  input  logic [DWIDTH-1:0]         data_in,
  input  logic                      pull,
  input  logic [CW-1:0]             pull_ch,
  input  logic [NCH-1:0]            flush,
  input  logic [NCH-1:0]            err_clr,
  output logic [DWIDTH-1:0]         data_out,
  output logic                      rvalid,
  output logic [CW-1:0]             rvalid_ch,
  output logic [NCH*(AWIDTH+1)-1:0] depth_left,
  output logic [NCH-1:0]            full,
  output logic [NCH-1:0]            empty,
  output logic [NCH-1:0]            almost_full,
  output logic [NCH-1:0]            almost_empty,
  output logic [NCH-1:0]            overflow,
  output logic [NCH-1:0]            underflow,
  output logic [CW+AWIDTH-1:0]      mem_waddr,
  output logic [CW+AWIDTH-1:0]      mem_raddr,
  output logic                      mem_write,
  output logic                      mem_read,
  output logic [DWIDTH-1:0]         mem_wdata,
  input  logic [DWIDTH-1:0]         mem_rdata
);

  localparam int DLW = AWIDTH + 1;
  localparam logic [AWIDTH:0] DEPTH_V = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AF_V    = DLW'(AF_LVL);
  localparam logic [AWIDTH:0] AE_V    = DLW'(AE_LVL);

  logic [AWIDTH-1:0] w_ptr [NCH];
  logic [AWIDTH-1:0] r_ptr [NCH];
  logic [AWIDTH:0]   dl    [NCH];
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    unf;

  logic [NCH-1:0]    push_sel, pull_sel;
  logic [NCH-1:0]    push_acc, pull_acc;
  logic [NCH-1:0]    push_err, pull_err;
  logic [AWIDTH-1:0] wsel_ptr, rsel_ptr;
  logic [AWIDTH:0]   occ;

  logic              vld_p1;
  logic [CW-1:0]     ch_p1;

  // Per-channel status flags and request qualification
  always_comb begin
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    depth_left   = '0;
    push_sel     = '0;
    pull_sel     = '0;
    push_acc     = '0;
    pull_acc     = '0;
    push_err     = '0;
    pull_err     = '0;
    wsel_ptr     = '0;
    rsel_ptr     = '0;
    occ          = '0;
    for (int c = 0; c < NCH; c++) begin
      occ                     = DEPTH_V - dl[c];
      full[c]                 = (dl[c] == '0);
      empty[c]                = (dl[c] == DEPTH_V);
      almost_full[c]          = (dl[c] <= AF_V);
      almost_empty[c]         = (occ <= AE_V);
      depth_left[c*DLW +: DLW] = dl[c];
      push_sel[c]             = push && (push_ch == CW'(c));
      pull_sel[c]             = pull && (pull_ch == CW'(c));
      push_acc[c]             = push_sel[c] && !full[c]  && !flush[c];
      pull_acc[c]             = pull_sel[c] && !empty[c] && !flush[c];
      push_err[c]             = push_sel[c] && full[c]   && !flush[c];
      pull_err[c]             = pull_sel[c] && empty[c]  && !flush[c];
      if (push_sel[c]) wsel_ptr = w_ptr[c];
      if (pull_sel[c]) rsel_ptr = r_ptr[c];
    end
  end

  // The RAM strobes are masked during reset so no stray write lands while rst is high
  assign mem_write = !rst && (|push_acc);
  assign mem_read  = !rst && (|pull_acc);
  assign mem_waddr = {push_ch, wsel_ptr};
  assign mem_raddr = {pull_ch, rsel_ptr};
  assign mem_wdata = data_in;

  assign overflow  = ovf;
  assign underflow = unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        w_ptr[c] <= '0;
        r_ptr[c] <= '0;
        dl[c]    <= DEPTH_V;
      end
      ovf <= '0;
      unf <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (flush[c]) begin
          w_ptr[c] <= '0;
          r_ptr[c] <= '0;
          dl[c]    <= DEPTH_V;
        end else begin
          if (push_acc[c]) w_ptr[c] <= w_ptr[c] + 1'b1;
          if (pull_acc[c]) r_ptr[c] <= r_ptr[c] + 1'b1;
          dl[c] <= dl[c] + DLW'(pull_acc[c]) - DLW'(push_acc[c]);
        end
        // A fresh error outranks a same-cycle clear
        if (push_err[c])                  ovf[c] <= 1'b1;
        else if (flush[c] || err_clr[c])  ovf[c] <= 1'b0;
        if (pull_err[c])                  unf[c] <= 1'b1;
        else if (flush[c] || err_clr[c])  unf[c] <= 1'b0;
      end
    end
  end

  // Stage p1: RAM read data returns one cycle after the accepted pull
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= |pull_acc;
  end

  always_ff @(posedge clk) begin
    ch_p1 <= pull_ch;
  end

  assign rvalid    = vld_p1;
  assign rvalid_ch = ch_p1;
  assign data_out  = vld_p1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dma_fifo_mc_exmem.sv
// Randomized scoreboard bench for dma_fifo_mc_exmem with a queue-based reference
// model and a behavioural 1-cycle-latency RAM.
module tb_dma_fifo_mc_exmem;
  localparam int DW = 64, AW = 8, NCH = 4, CW = 2, DEPTH = 256, DLW = 9;
  localparam int AF = 4, AE = 4;

  logic clk = 1'b0;
  logic rst;
  logic push, pull;
  logic [CW-1:0] push_ch, pull_ch, rvalid_ch;
  logic [DW-1:0] data_in, data_out, mem_wdata, mem_rdata;
  logic [NCH-1:0] flush, err_clr, full, empty, almost_full, almost_empty, overflow, underflow;
  logic rvalid, mem_write, mem_read;
  logic [NCH*DLW-1:0] depth_left;
  logic [CW+AW-1:0] mem_waddr, mem_raddr;

  always #5 clk = ~clk;

  dma_fifo_mc_exmem #(.DWIDTH(DW), .AWIDTH(AW), .NCH(NCH), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk(clk), .rst(rst), .push(push), .push_ch(push_ch), .data_in(data_in),
    .pull(pull), .pull_ch(pull_ch), .flush(flush), .err_clr(err_clr),
    .data_out(data_out), .rvalid(rvalid), .rvalid_ch(rvalid_ch), .depth_left(depth_left),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_write(mem_write), .mem_read(mem_read), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // External RAM, registered read
  logic [DW-1:0] ram [NCH*DEPTH];
  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_wdata;
    if (mem_read)  mem_rdata <= ram[mem_raddr];
  end

  // Reference model: one data queue per channel plus sticky flags
  logic [DW-1:0] mq [NCH][$];
  int wcnt [NCH];
  int rcnt [NCH];
  logic [NCH-1:0] ov_m, un_m;

  typedef struct {
    logic [CW-1:0] ch;
    logic [DW-1:0] d;
    time           t;
  } exp_t;
  exp_t expq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      wcnt[c] = 0;
      rcnt[c] = 0;
    end
    ov_m = '0;
    un_m = '0;
    expq.delete();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_depth_left"}, depth_left, {NCH{9'd256}});
    chk({tag, "_empty"}, empty, {NCH{1'b1}});
    chk({tag, "_full"}, full, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_underflow"}, underflow, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
  endtask

  task automatic check_state();
    logic [NCH*DLW-1:0] dle;
    logic [NCH-1:0] fe, ee, afe, aee;
    int free;
    for (int c = 0; c < NCH; c++) begin
      free = DEPTH - mq[c].size();
      dle[c*DLW +: DLW] = DLW'(free);
      fe[c]  = (free == 0);
      ee[c]  = (free == DEPTH);
      afe[c] = (free <= AF);
      aee[c] = (mq[c].size() <= AE);
    end
    chk("depth_left", depth_left, dle);
    chk("full", full, fe);
    chk("empty", empty, ee);
    chk("almost_full", almost_full, afe);
    chk("almost_empty", almost_empty, aee);
    chk("overflow", overflow, ov_m);
    chk("underflow", underflow, un_m);
  endtask

  task automatic step(input bit p, input int pc, input logic [DW-1:0] d,
                      input bit r, input int rc,
                      input logic [NCH-1:0] fl, input logic [NCH-1:0] ec);
    bit pa, ra, pe, re;
    logic [DW-1:0] front;
    @(negedge clk);
    #1;
    check_state();
    push = p; push_ch = CW'(pc); data_in = d;
    pull = r; pull_ch = CW'(rc);
    flush = fl; err_clr = ec;
    pa = p && (mq[pc].size() < DEPTH) && !fl[pc];
    pe = p && (mq[pc].size() == DEPTH) && !fl[pc];
    ra = r && (mq[rc].size() > 0) && !fl[rc];
    re = r && (mq[rc].size() == 0) && !fl[rc];
    #1;
    chk("mem_write", mem_write, pa);
    if (pa) begin
      chk("mem_waddr", mem_waddr, pc * DEPTH + (wcnt[pc] % DEPTH));
      chk("mem_wdata", mem_wdata, d);
    end
    chk("mem_read", mem_read, ra);
    if (ra) chk("mem_raddr", mem_raddr, rc * DEPTH + (rcnt[rc] % DEPTH));
    @(posedge clk);
    if (ra) begin
      front = mq[rc].pop_front();
      expq.push_back('{ch: CW'(rc), d: front, t: $time});
      rcnt[rc]++;
    end
    if (pa) begin
      mq[pc].push_back(d);
      wcnt[pc]++;
    end
    for (int c = 0; c < NCH; c++) begin
      if (ec[c] || fl[c]) begin
        ov_m[c] = 1'b0;
        un_m[c] = 1'b0;
      end
      if (fl[c]) begin
        mq[c].delete();
        wcnt[c] = 0;
        rcnt[c] = 0;
      end
    end
    if (pe) ov_m[pc] = 1'b1;
    if (re) un_m[rc] = 1'b1;
    #1;
    push = 0; pull = 0; flush = '0; err_clr = '0;
  endtask

  task automatic psh(input int c, input logic [DW-1:0] d);
    step(1, c, d, 0, 0, '0, '0);
  endtask

  task automatic pll(input int c);
    step(0, 0, '0, 1, c, '0, '0);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard monitor: read words are checked when the DUT presents them
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rvalid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got ch=%0d data=%0h expected no word", rvalid_ch, data_out);
        end else begin
          e = expq.pop_front();
          chk("rvalid_ch", rvalid_ch, e.ch);
          chk("data_out", data_out, e.d);
          chk("rvalid_latency", 64'($time - e.t), 64'd5);
        end
      end else begin
        chk("data_out_idle", data_out, 0);
        if (expq.size() > 0 && ($time - expq[0].t) >= 5) begin
          e = expq.pop_front();
          chk("rvalid_missing", rvalid, 1);
        end
      end
    end
  end

  initial begin
    model_reset();
    rst = 1; push = 1; pull = 1; push_ch = '0; pull_ch = '0;
    data_in = '1; flush = '0; err_clr = '0;
    #2;
    reset_check("reset");
    repeat (2) @(posedge clk);
    push = 0; pull = 0;
    @(negedge clk);
    rst = 0;

    // In-order delivery on one channel
    for (int i = 0; i < 4; i++) psh(1, 64'hA0 + 64'(i));
    for (int i = 0; i < 4; i++) pll(1);

    // Fill ch0, then overflow it
    for (int i = 0; i < DEPTH; i++) psh(0, rnd64());
    psh(0, rnd64());

    // Full ch2 with simultaneous push and pull, then steady state at 10 entries
    for (int i = 0; i < DEPTH; i++) psh(2, rnd64());
    step(1, 2, rnd64(), 1, 2, '0, '0);
    step(0, 0, '0, 0, 0, 4'b0100, '0);
    for (int i = 0; i < 10; i++) psh(2, rnd64());
    step(1, 2, rnd64(), 1, 2, '0, '0);
    step(1, 2, rnd64(), 1, 2, '0, '0);

    // Pointer wrap on ch3
    psh(3, rnd64());
    for (int i = 0; i < 300; i++) step(1, 3, rnd64(), 1, 3, '0, '0);
    pll(3);

    // Underflow, error clear, flush racing a push
    step(0, 0, '0, 0, 0, 4'b0001, '0);
    pll(0);
    step(0, 0, '0, 0, 0, '0, 4'b0001);
    for (int i = 0; i < 5; i++) psh(1, rnd64());
    step(1, 1, rnd64(), 0, 0, 4'b0010, '0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [NCH-1:0] fl, ec;
      fl = '0; ec = '0;
      for (int c = 0; c < NCH; c++) begin
        fl[c] = ($urandom_range(0, 99) == 0);
        ec[c] = ($urandom_range(0, 31) == 0);
      end
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, NCH-1)), rnd64(),
           $urandom_range(0, 99) < 50, int'($urandom_range(0, NCH-1)), fl, ec);
    end

    // Asynchronous reset with data in every channel and a read in flight
    for (int c = 0; c < NCH; c++) psh(c, rnd64());
    pll(0);
    #1;
    rst = 1;
    #1;
    reset_check("async_reset");
    model_reset();
    @(negedge clk);
    #2;
    rst = 0;

    psh(2, 64'h1234);
    pll(2);
    repeat (3) step(0, 0, '0, 0, 0, '0, '0);
    chk("scoreboard_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
